imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational immediate generator in the decode stage.
- Decodes every RV32I/RV64I immediate format, classifies it, and flags opcodes that carry no recognised immediate.
- Registers results behind a valid/ready handshake with a skid buffer, so it sustains full throughput under back-pressure from issue.
- Also counts unrecognised opcodes for debug.

---
 rtl/imm_gen_pipe.sv | 158 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a valid/ready output register, one-entry skid buffer
// and a saturating illegal-opcode counter. Define IMM_GEN_ZICSR_EN to decode CSR uimm immediates.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] FMT_CSR   = 3'd7;
`endif
  localparam bit IS64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t             r_out, r_skid, w_dec;
  logic             r_out_vld, r_skid_vld;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_sh;
  logic        w_acc;
  logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [63:0] w_imm64;
  logic [2:0]  w_fmt;
  logic        w_ill;

  assign w_op  = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_sh  = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_acc = in_valid && in_ready;

  // Everything is built at 64 bits and truncated so XLEN=32 needs no zero-width replications.
  assign w_imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign w_imm_j = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    w_imm64 = '0;
    w_fmt   = FMT_NONE;
    w_ill   = 1'b0;
    case (w_op)
      7'b0010011: begin
        if (w_sh) begin
          w_fmt = FMT_SHAMT;
          if (IS64) w_imm64 = {58'b0, in_instr[25:20]};
          else begin
            w_imm64 = {59'b0, in_instr[24:20]};
            w_ill   = in_instr[25];
          end
        end else begin
          w_fmt   = FMT_I;
          w_imm64 = w_imm_i;
        end
      end
      7'b0000011, 7'b1100111: begin w_fmt = FMT_I; w_imm64 = w_imm_i; end
      7'b0100011: begin w_fmt = FMT_S; w_imm64 = w_imm_s; end
      7'b1100011: begin w_fmt = FMT_B; w_imm64 = w_imm_b; end
      7'b0110111, 7'b0010111: begin w_fmt = FMT_U; w_imm64 = w_imm_u; end
      7'b1101111: begin w_fmt = FMT_J; w_imm64 = w_imm_j; end
      7'b0011011: begin
        if (!IS64) w_ill = 1'b1;
        else if (w_sh) begin
          w_fmt   = FMT_SHAMT;
          w_imm64 = {59'b0, in_instr[24:20]};
          w_ill   = in_instr[25];
        end else begin
          w_fmt   = FMT_I;
          w_imm64 = w_imm_i;
        end
      end
      7'b0111011: w_ill = !IS64;
      7'b0110011, 7'b0001111: ;
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        if (w_f3[2] && (w_f3[1:0] != 2'b00)) begin
          w_fmt   = FMT_CSR;
          w_imm64 = {59'b0, in_instr[19:15]};
        end
      end
`else
      7'b1110011: ;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_dec.imm = w_imm64[XLEN-1:0];
    w_dec.fmt = w_fmt;
    w_dec.ill = w_ill;
    w_dec.tag = in_tag;
  end

  // Output register refills from the skid first, so ordering is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (!r_out_vld || out_ready) begin
        if (r_skid_vld) begin
          r_out      <= r_skid;
          r_out_vld  <= 1'b1;
          r_skid_vld <= 1'b0;
        end else begin
          r_out_vld <= w_acc;
          if (w_acc) r_out <= w_dec;
        end
      end else if (w_acc) begin
        r_skid     <= w_dec;
        r_skid_vld <= 1'b1;
      end
      if (w_acc && w_dec.ill && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = !r_skid_vld;
  assign out_valid   = r_out_vld;
  assign out_imm     = r_out.imm;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.ill;
  assign out_tag     = r_out.tag;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 instance (16-bit counter) and an RV64 instance (2-bit counter)
// share one stimulus stream and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic [7:0]  a_tag;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;
  logic [7:0]  b_tag;
  logic [1:0]  b_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill), .out_tag(a_tag),
    .illegal_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill), .out_tag(b_tag),
    .illegal_cnt(b_cnt));

  typedef struct {
    logic [63:0] i32, i64;
    logic [2:0]  f32, f64;
    logic        l32, l64;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   cnt32 = 0;
  int   cnt64 = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference decode written from the ISA immediate rules as signed arithmetic.
  function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    logic [2:0] f3;
    bit sh;
    f3  = ins[14:12];
    sh  = (f3 == 3'd1) || (f3 == 3'd5);
    imm = '0; fmt = 3'd0; ill = 1'b0;
    case (ins[6:0])
      7'h13: if (sh) begin
               fmt = 3'd6;
               if (xlen == 64) imm = 64'(ins[25:20]);
               else begin imm = 64'(ins[24:20]); ill = ins[25]; end
             end else begin fmt = 3'd1; imm = longint'($signed(ins[31:20])); end
      7'h03, 7'h67: begin fmt = 3'd1; imm = longint'($signed(ins[31:20])); end
      7'h23: begin fmt = 3'd2; imm = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin fmt = 3'd3; imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2; end
      7'h37, 7'h17: begin fmt = 3'd4; imm = longint'($signed(ins[31:12])) * 4096; end
      7'h6f: begin fmt = 3'd5; imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2; end
      7'h1b: if (xlen != 64) ill = 1'b1;
             else if (sh) begin fmt = 3'd6; imm = 64'(ins[24:20]); ill = ins[25]; end
             else begin fmt = 3'd1; imm = longint'($signed(ins[31:20])); end
      7'h3b: ill = (xlen != 64);
      7'h33, 7'h0f: ;
      7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
        if (f3 >= 3'd5) begin fmt = 3'd7; imm = 64'(ins[19:15]); end
`endif
      end
      default: ill = 1'b1;
    endcase
    if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  task automatic check_outputs();
    chk("a_in_ready", 64'(a_in_ready), 64'(q.size() < 2));
    chk("b_in_ready", 64'(b_in_ready), 64'(q.size() < 2));
    chk("a_out_valid", 64'(a_out_valid), 64'(q.size() > 0));
    chk("b_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
    chk("a_cnt", 64'(a_cnt), 64'(cnt32));
    chk("b_cnt", 64'(b_cnt), 64'(cnt64));
    if (q.size() > 0) begin
      chk("a_imm", 64'(a_imm), q[0].i32);
      chk("a_fmt", 64'(a_fmt), 64'(q[0].f32));
      chk("a_ill", 64'(a_ill), 64'(q[0].l32));
      chk("a_tag", 64'(a_tag), 64'(q[0].tag));
      chk("b_imm", b_imm, q[0].i64);
      chk("b_fmt", 64'(b_fmt), 64'(q[0].f64));
      chk("b_ill", 64'(b_ill), 64'(q[0].l64));
      chk("b_tag", 64'(b_tag), 64'(q[0].tag));
    end
  endtask

  // One clock: drive, check before the edge, then advance the model after it.
  task automatic step(input logic v, input logic [31:0] ins, input logic [7:0] tg, input logic rdy);
    exp_t e;
    bit acc, cons;
    in_valid = v; in_instr = ins; in_tag = tg; out_ready = rdy;
    #3;
    check_outputs();
    acc  = v && (q.size() < 2);
    cons = rdy && (q.size() > 0);
    ref_dec(ins, 32, e.i32, e.f32, e.l32);
    ref_dec(ins, 64, e.i64, e.f64, e.l64);
    e.tag = tg;
    @(posedge clk); #1;
    if (cons) void'(q.pop_front());
    if (acc) begin
      q.push_back(e);
      if (e.l32 && cnt32 < 65535) cnt32++;
      if (e.l64 && cnt64 < 3) cnt64++;
    end
  endtask

  initial begin
    logic [6:0]  ops [14];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f,
            7'h1b, 7'h33, 7'h3b, 7'h0f, 7'h73, 7'h7f};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_imm", 64'(a_imm), 64'd0);
    chk("rst_fmt", 64'(a_fmt), 64'd0);
    chk("rst_ill", 64'(a_ill), 64'd0);
    chk("rst_tag", 64'(a_tag), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_b_imm", b_imm, 64'd0);
    rst_n = 1'b1;

    step(1'b1, 32'hFFF00093, 8'h11, 1'b1);
    chk("addi_valid", 64'(a_out_valid), 64'd1);
    chk("addi_imm", 64'(a_imm), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(a_fmt), 64'd1);
    chk("addi_tag", 64'(a_tag), 64'h11);

    step(1'b1, 32'hFFC0A103, 8'h21, 1'b1);
    chk("lw_imm", 64'(a_imm), 64'hFFFF_FFFC);
    step(1'b1, 32'hFE000CE3, 8'h22, 1'b1);
    chk("beq_imm", 64'(a_imm), 64'hFFFF_FFF8);
    chk("beq_fmt", 64'(a_fmt), 64'd3);
    step(1'b1, 32'h12345037, 8'h23, 1'b1);
    chk("lui_imm", 64'(a_imm), 64'h1234_5000);
    chk("lui_fmt", 64'(a_fmt), 64'd4);
    step(1'b0, 32'h0, 8'h0, 1'b1);

    step(1'b1, 32'h00500093, 8'h31, 1'b0);
    step(1'b1, 32'h00A00113, 8'h32, 1'b0);
    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
    step(1'b1, 32'h00F00193, 8'h33, 1'b0);
    step(1'b0, 32'h0, 8'h0, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1);

    step(1'b1, 32'h0000007F, 8'h41, 1'b1);
    step(1'b1, 32'h02009093, 8'h42, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1);
    chk("ill_cnt2", 64'(a_cnt), 64'd2);
    repeat (4) step(1'b1, 32'h0000007F, 8'h43, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1);
    chk("sat_cnt", 64'(b_cnt), 64'd3);

    step(1'b1, 32'h03F09093, 8'h51, 1'b1);
    chk("slli63_imm", b_imm, 64'd63);
    chk("slli63_fmt", 64'(b_fmt), 64'd6);
    chk("slli63_ill", 64'(b_ill), 64'd0);
    step(1'b0, 32'h0, 8'h0, 1'b1);

    step(1'b1, 32'h00100093, 8'h61, 1'b0);
    step(1'b1, 32'h00200093, 8'h62, 1'b0);
    step(1'b1, 32'h0000007F, 8'h63, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("mrst_in_ready", 64'(a_in_ready), 64'd1);
    chk("mrst_cnt", 64'(a_cnt), 64'd0);
    chk("mrst_b_valid", 64'(b_out_valid), 64'd0);
    q.delete();
    cnt32 = 0;
    cnt64 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 32'hFFF00093, 8'h71, 1'b1);
    chk("post_rst_valid", 64'(a_out_valid), 64'd1);
    chk("post_rst_tag", 64'(a_tag), 64'h71);

    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      step($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 13)]},
           8'($urandom()), $urandom_range(0, 2) != 0);
    end
    repeat (3) step(1'b0, 32'h0, 8'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
